// File: rtl/watch_rtc_core.sv
// Calendar/clock core: Y/M/D h:m:s with Gregorian leap years, weekday counter,
// validated two-step time load and a latched one-shot h:m alarm.
//
// state   | meaning
// S_IDLE  | counting; set_req captures the load values into shadow registers
// S_CHECK | shadow values validated; commit (ack) or reject (err), back to idle
module watch_rtc_core #(
  parameter int YEAR_W    = 12,
  parameter int YEAR_MIN  = 1,
  parameter int YEAR_MAX  = 4095,
  parameter int RST_YEAR  = 2021,
  parameter int RST_MONTH = 5,
  parameter int RST_DAY   = 30,
  parameter int RST_WEEK  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              set_req,
  input  logic [YEAR_W-1:0] set_year,
  input  logic [7:0]        set_month,
  input  logic [7:0]        set_day,
  input  logic [7:0]        set_hour,
  input  logic [7:0]        set_minute,
  input  logic [7:0]        set_second,
  input  logic [2:0]        set_week,
  output logic              set_ack,
  output logic              set_err,
  input  logic              alarm_en,
  input  logic [7:0]        alarm_hour,
  input  logic [7:0]        alarm_minute,
  input  logic              alarm_clr,
  output logic              alarm_pending,
  output logic [YEAR_W-1:0] year,
  output logic [7:0]        month,
  output logic [7:0]        day,
  output logic [7:0]        hour,
  output logic [7:0]        minute,
  output logic [7:0]        second,
  output logic [2:0]        week,
  output logic [4:0]        max_date,
  output logic              day_wrap
);

  typedef enum logic {S_IDLE, S_CHECK} state_t;

  localparam logic [YEAR_W-1:0] Y_MIN  = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] Y_ONE  = YEAR_W'(1);
  localparam logic [YEAR_W-1:0] Y_RST  = YEAR_W'(RST_YEAR);
  localparam logic [7:0]        MO_RST = 8'(RST_MONTH);
  localparam logic [7:0]        D_RST  = 8'(RST_DAY);
  localparam logic [2:0]        W_RST  = 3'(RST_WEEK);

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    int unsigned yy;
    yy = 32'(y);
    return ((yy % 4 == 0) && (yy % 100 != 0)) || (yy % 400 == 0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [7:0] m,
                                               input logic [YEAR_W-1:0] y);
    logic [4:0] d;
    case (m)
      8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: d = 5'd31;
      8'd4, 8'd6, 8'd9, 8'd11:                    d = 5'd30;
      8'd2:    d = is_leap(y) ? 5'd29 : 5'd28;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  state_t state, state_next;

  logic [YEAR_W-1:0] sh_year;
  logic [7:0]        sh_month, sh_day, sh_hour, sh_minute, sh_second;
  logic [2:0]        sh_week;
  logic [4:0]        sh_max;
  logic              set_valid;

  logic              capture, load_ok, load_bad;

  logic [YEAR_W-1:0] t_year;
  logic [7:0]        t_month, t_day, t_hour, t_minute, t_second;
  logic [2:0]        t_week;
  logic              t_wrap;
  logic              alarm_hit;

  assign max_date = days_in_month(month, year);
  assign sh_max   = days_in_month(sh_month, sh_year);

  assign set_valid = (32'(sh_year) >= YEAR_MIN) && (32'(sh_year) <= YEAR_MAX) &&
                     (sh_month >= 8'd1) && (sh_month <= 8'd12) &&
                     (sh_day >= 8'd1) && (sh_day <= {3'b000, sh_max}) &&
                     (sh_hour < 8'd24) && (sh_minute < 8'd60) &&
                     (sh_second < 8'd60) && (sh_week < 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_ok    = 1'b0;
    load_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (set_req) begin
          capture    = 1'b1;
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        state_next = S_IDLE;
        if (set_valid) load_ok  = 1'b1;
        else           load_bad = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Value every field would take if this cycle's tick were applied.
  always_comb begin
    t_year   = year;
    t_month  = month;
    t_day    = day;
    t_hour   = hour;
    t_minute = minute;
    t_second = second;
    t_week   = week;
    t_wrap   = 1'b0;
    if (second < 8'd59) begin
      t_second = second + 8'd1;
    end else begin
      t_second = 8'd0;
      if (minute < 8'd59) begin
        t_minute = minute + 8'd1;
      end else begin
        t_minute = 8'd0;
        if (hour < 8'd23) begin
          t_hour = hour + 8'd1;
        end else begin
          t_hour = 8'd0;
          t_wrap = 1'b1;
          t_week = (week >= 3'd6) ? 3'd0 : week + 3'd1;
          if (day < {3'b000, max_date}) begin
            t_day = day + 8'd1;
          end else begin
            t_day = 8'd1;
            if (month < 8'd12) begin
              t_month = month + 8'd1;
            end else begin
              t_month = 8'd1;
              t_year  = (year == Y_MAX) ? Y_MIN : year + Y_ONE;
            end
          end
        end
      end
    end
  end

  // A committed load swallows the tick, so it can never raise the alarm.
  assign alarm_hit = tick && !load_ok && alarm_en && (t_second == 8'd0) &&
                     (t_minute == alarm_minute) && (t_hour == alarm_hour);

  always_ff @(posedge clk) begin
    if (!rst) begin
      year          <= Y_RST;
      month         <= MO_RST;
      day           <= D_RST;
      hour          <= 8'd0;
      minute        <= 8'd0;
      second        <= 8'd0;
      week          <= W_RST;
      set_ack       <= 1'b0;
      set_err       <= 1'b0;
      alarm_pending <= 1'b0;
      day_wrap      <= 1'b0;
      sh_year       <= '0;
      sh_month      <= 8'd0;
      sh_day        <= 8'd0;
      sh_hour       <= 8'd0;
      sh_minute     <= 8'd0;
      sh_second     <= 8'd0;
      sh_week       <= 3'd0;
    end else begin
      set_ack  <= load_ok;
      set_err  <= load_bad;
      day_wrap <= 1'b0;
      if (capture) begin
        sh_year   <= set_year;
        sh_month  <= set_month;
        sh_day    <= set_day;
        sh_hour   <= set_hour;
        sh_minute <= set_minute;
        sh_second <= set_second;
        sh_week   <= set_week;
      end
      if (load_ok) begin
        year   <= sh_year;
        month  <= sh_month;
        day    <= sh_day;
        hour   <= sh_hour;
        minute <= sh_minute;
        second <= sh_second;
        week   <= sh_week;
      end else if (tick) begin
        year     <= t_year;
        month    <= t_month;
        day      <= t_day;
        hour     <= t_hour;
        minute   <= t_minute;
        second   <= t_second;
        week     <= t_week;
        day_wrap <= t_wrap;
      end
      if (alarm_hit)      alarm_pending <= 1'b1;
      else if (alarm_clr) alarm_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_watch_rtc_core.sv
// Bench for watch_rtc_core: directed rollover table, set/alarm/reset sequences,
// then random traffic checked against a seconds-of-day calendar model.
module tb_watch_rtc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        set_req = 1'b0;
  logic [11:0] set_year = '0;
  logic [7:0]  set_month = '0, set_day = '0, set_hour = '0, set_minute = '0, set_second = '0;
  logic [2:0]  set_week = '0;
  logic        set_ack, set_err;
  logic        alarm_en = 1'b0;
  logic [7:0]  alarm_hour = '0, alarm_minute = '0;
  logic        alarm_clr = 1'b0;
  logic        alarm_pending;
  logic [11:0] year;
  logic [7:0]  month, day, hour, minute, second;
  logic [2:0]  week;
  logic [4:0]  max_date;
  logic        day_wrap;

  always #5 clk = ~clk;

  watch_rtc_core dut (
    .clk(clk), .rst(rst), .tick(tick), .set_req(set_req),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .set_week(set_week), .set_ack(set_ack), .set_err(set_err),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
    .alarm_clr(alarm_clr), .alarm_pending(alarm_pending),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
    .second(second), .week(week), .max_date(max_date), .day_wrap(day_wrap)
  );

  typedef struct { int y; int mo; int d; int h; int mi; int s; int w; } ts_t;
  typedef struct { ts_t ld; ts_t exp; bit exp_wrap; } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: date plus time of day as a plain second count.
  int  m_y, m_mo, m_d, m_sod, m_w;
  bit  m_pend, m_checking, e_ack, e_err, e_wrap;
  ts_t m_req;

  function automatic ts_t mk(int y, int mo, int d, int h, int mi, int s, int w);
    ts_t t;
    t.y = y; t.mo = mo; t.d = d; t.h = h; t.mi = mi; t.s = s; t.w = w;
    return t;
  endfunction

  function automatic bit leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int dim(int m, int y);
    case (m)
      1, 3, 5, 7, 8, 10, 12: return 31;
      4, 6, 9, 11:           return 30;
      2:                     return leap(y) ? 29 : 28;
      default:               return 0;
    endcase
  endfunction

  function automatic bit ts_ok(ts_t t);
    return t.y >= 1 && t.y <= 4095 && t.mo >= 1 && t.mo <= 12 &&
           t.d >= 1 && t.d <= dim(t.mo, t.y) && t.h < 24 && t.mi < 60 &&
           t.s < 60 && t.w < 7;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 2021; m_mo = 5; m_d = 30; m_sod = 0; m_w = 0;
    m_pend = 0; m_checking = 0; e_ack = 0; e_err = 0; e_wrap = 0;
  endtask

  task automatic model_tick();
    m_sod++;
    if (m_sod == 86400) begin
      m_sod = 0;
      e_wrap = 1;
      m_w = (m_w + 1) % 7;
      m_d++;
      if (m_d > dim(m_mo, m_y)) begin
        m_d = 1;
        m_mo++;
        if (m_mo > 12) begin
          m_mo = 1;
          m_y = (m_y == 4095) ? 1 : m_y + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("year", int'(year), m_y);
    chk("month", int'(month), m_mo);
    chk("day", int'(day), m_d);
    chk("hour", int'(hour), m_sod / 3600);
    chk("minute", int'(minute), (m_sod / 60) % 60);
    chk("second", int'(second), m_sod % 60);
    chk("week", int'(week), m_w);
    chk("max_date", int'(max_date), dim(m_mo, m_y));
    chk("day_wrap", int'(day_wrap), int'(e_wrap));
    chk("set_ack", int'(set_ack), int'(e_ack));
    chk("set_err", int'(set_err), int'(e_err));
    chk("alarm_pending", int'(alarm_pending), int'(m_pend));
  endtask

  // One clock: predict from the currently driven inputs, step, then compare.
  task automatic cycle();
    bit tick_eff, hit;
    e_ack = 0; e_err = 0; e_wrap = 0;
    if (!rst) begin
      model_reset();
    end else begin
      tick_eff = tick;
      if (m_checking) begin
        m_checking = 0;
        if (ts_ok(m_req)) begin
          m_y = m_req.y; m_mo = m_req.mo; m_d = m_req.d; m_w = m_req.w;
          m_sod = m_req.h * 3600 + m_req.mi * 60 + m_req.s;
          e_ack = 1;
          tick_eff = 0;
        end else begin
          e_err = 1;
        end
      end else if (set_req) begin
        m_checking = 1;
        m_req = mk(int'(set_year), int'(set_month), int'(set_day), int'(set_hour),
                   int'(set_minute), int'(set_second), int'(set_week));
      end
      if (tick_eff) model_tick();
      hit = tick_eff && alarm_en && (m_sod % 60 == 0) &&
            (m_sod / 3600 == int'(alarm_hour)) && ((m_sod / 60) % 60 == int'(alarm_minute));
      if (hit) m_pend = 1;
      else if (alarm_clr) m_pend = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive_set(ts_t t);
    set_year = 12'(t.y); set_month = 8'(t.mo); set_day = 8'(t.d);
    set_hour = 8'(t.h); set_minute = 8'(t.mi); set_second = 8'(t.s); set_week = 3'(t.w);
  endtask

  task automatic do_load(ts_t t, bit tk_idle, bit tk_chk);
    drive_set(t);
    set_req = 1; tick = tk_idle;
    cycle();
    set_req = 0; tick = tk_chk;
    cycle();
    tick = 0;
  endtask

  function automatic ts_t rand_ts();
    ts_t t;
    int  pick;
    if ($urandom_range(0, 3) != 0) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: t.y = 2000;
        1: t.y = 2100;
        2: t.y = 2024;
        3: t.y = 4095;
        4: t.y = 1;
        default: t.y = $urandom_range(1, 4095);
      endcase
      t.mo = $urandom_range(1, 12); t.d = $urandom_range(1, 31);
      t.h = $urandom_range(22, 23); t.mi = $urandom_range(58, 59);
      t.s = $urandom_range(55, 59); t.w = $urandom_range(0, 6);
      if (t.d > 28 && $urandom_range(0, 1) == 1) t.d = dim(t.mo, t.y);
    end else begin
      t.y = $urandom_range(0, 4095); t.mo = $urandom_range(0, 13);
      t.d = $urandom_range(0, 33); t.h = $urandom_range(0, 25);
      t.mi = $urandom_range(0, 61); t.s = $urandom_range(0, 61); t.w = $urandom_range(0, 7);
    end
    return t;
  endfunction

  vec_t vt[7];

  initial begin
    vt[0] = '{mk(2023, 12, 31, 23, 59, 59, 0), mk(2024, 1, 1, 0, 0, 0, 1), 1'b1};
    vt[1] = '{mk(2024, 2, 28, 23, 59, 59, 3), mk(2024, 2, 29, 0, 0, 0, 4), 1'b1};
    vt[2] = '{mk(2100, 2, 28, 23, 59, 59, 0), mk(2100, 3, 1, 0, 0, 0, 1), 1'b1};
    vt[3] = '{mk(4095, 12, 31, 23, 59, 59, 6), mk(1, 1, 1, 0, 0, 0, 0), 1'b1};
    vt[4] = '{mk(2021, 6, 30, 12, 59, 59, 2), mk(2021, 6, 30, 13, 0, 0, 2), 1'b0};
    vt[5] = '{mk(2000, 2, 28, 23, 59, 59, 1), mk(2000, 2, 29, 0, 0, 0, 2), 1'b1};
    vt[6] = '{mk(2023, 4, 30, 23, 59, 59, 5), mk(2023, 5, 1, 0, 0, 0, 6), 1'b1};

    // Reset and release
    model_reset();
    rst = 0;
    cycle();
    cycle();
    rst = 1;
    cycle();
    chk("rst_year", int'(year), 2021);
    chk("rst_month", int'(month), 5);
    chk("rst_day", int'(day), 30);
    chk("rst_week", int'(week), 0);
    chk("rst_flags", int'({set_ack, set_err, alarm_pending, day_wrap}), 0);

    // Rollover table
    for (int i = 0; i < 7; i++) begin
      do_load(vt[i].ld, 1'b0, 1'b0);
      chk("tbl_ack", int'(set_ack), 1);
      tick = 1;
      cycle();
      tick = 0;
      chk("tbl_year", int'(year), vt[i].exp.y);
      chk("tbl_month", int'(month), vt[i].exp.mo);
      chk("tbl_day", int'(day), vt[i].exp.d);
      chk("tbl_hms", int'(hour) * 3600 + int'(minute) * 60 + int'(second),
          vt[i].exp.h * 3600 + vt[i].exp.mi * 60 + vt[i].exp.s);
      chk("tbl_week", int'(week), vt[i].exp.w);
      chk("tbl_wrap", int'(day_wrap), int'(vt[i].exp_wrap));
      cycle();
    end

    // Invalid load: rejected, tick in the check cycle still counts
    do_load(mk(2023, 2, 29, 10, 0, 0, 3), 1'b0, 1'b1);
    chk("t4_err", int'(set_err), 1);
    chk("t4_err_ack", int'(set_ack), 0);
    chk("t4_err_year", int'(year), 2023);
    // Valid load: ack two cycles after request, check-cycle tick dropped
    drive_set(mk(2000, 2, 29, 10, 20, 30, 2));
    set_req = 1; tick = 1;
    cycle();
    chk("t4_ack_early", int'(set_ack), 0);
    set_req = 0;
    cycle();
    tick = 0;
    chk("t4_ack", int'(set_ack), 1);
    chk("t4_second", int'(second), 30);
    chk("t4_day", int'(day), 29);
    cycle();

    // Alarm
    alarm_en = 1; alarm_hour = 8'd7; alarm_minute = 8'd30;
    do_load(mk(2022, 3, 3, 7, 29, 59, 4), 1'b0, 1'b0);
    chk("t5_pre", int'(alarm_pending), 0);
    tick = 1;
    cycle();
    tick = 0;
    chk("t5_hit", int'(alarm_pending), 1);
    do_load(mk(2022, 3, 3, 7, 29, 59, 4), 1'b0, 1'b0);
    tick = 1; alarm_clr = 1;
    cycle();
    tick = 0;
    chk("t5_clr_vs_hit", int'(alarm_pending), 1);
    cycle();
    alarm_clr = 0;
    chk("t5_clr", int'(alarm_pending), 0);
    do_load(mk(2022, 3, 3, 7, 30, 0, 4), 1'b0, 1'b0);
    chk("t5_load_no_hit", int'(alarm_pending), 0);
    do_load(mk(2022, 3, 3, 7, 29, 59, 4), 1'b0, 1'b0);
    tick = 1;
    cycle();
    tick = 0; alarm_en = 0;
    cycle();
    chk("t5_en_off_keeps", int'(alarm_pending), 1);
    alarm_clr = 1;
    cycle();
    alarm_clr = 0;

    // Reset during the check cycle aborts the load
    drive_set(mk(2030, 1, 1, 1, 1, 1, 1));
    set_req = 1;
    cycle();
    set_req = 0; rst = 0;
    cycle();
    chk("t6_ack", int'(set_ack), 0);
    chk("t6_err", int'(set_err), 0);
    chk("t6_year", int'(year), 2021);
    rst = 1;
    cycle();
    chk("t6_after_ack", int'({set_ack, set_err}), 0);

    // Random traffic
    for (int n = 0; n < 5000; n++) begin
      ts_t r;
      tick = ($urandom_range(0, 3) != 0);
      set_req = ($urandom_range(0, 29) == 0);
      if (set_req) begin
        r = rand_ts();
        drive_set(r);
        alarm_hour = 8'(r.h);
        alarm_minute = 8'((r.mi + 1) % 60);
      end
      alarm_en = ($urandom_range(0, 9) != 0);
      alarm_clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 799) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
